pb_poll: RTL and testbench
==========================

Name: pb_poll

Overview:
- Reader-side companion to the pushbutton conditioner.
- Periodically polls the conditioner's latched, clear-on-read press flag and issues the read strobe that clears it.
- Classifies presses into click, double-click and long-hold events. Event flags are sticky, and a host read clears them.
- Sits between the conditioner and the encoder/peripheral register interface.

Parameters:
- POLL_W, 16: poll timer width; one poll every 2^POLL_W clocks.
- HOLD_CNT, 50: consecutive pressed polls that constitute a long hold; minimum 2.
- DBL_CNT, 15: released polls allowed before a second press counts as a double-click; minimum 1.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  async. reset, active low.
- pb_i  in  1  latched press flag from conditioner, active high.
- pb_rd_o  out  1  read/clear strobe to conditioner, 1-cycle pulse.
- rd_i  in  1  host read of event flags, active high.
- evt_o  out  3  sticky event flags {long, dbl, click}.
- held_o  out  1  high while a long hold is in progress.

Behaviour:
- Clock and reset:
  - One clock, clk_i. Reset rst_n_i is asynchronous and active-low.
  - Reset values: pb_rd_o=0, evt_o=0, held_o=0, poll timer=0, hold/window counter=0, state=IDLE.
  - Reset asserted mid-operation aborts any state immediately.
- Poll timer:
  - POLL_W-bit free-running counter.
  - When it reaches all-ones, pb_rd_o is registered high for exactly the next cycle (the "tick"). The first tick occurs 2^POLL_W clocks after reset release.
  - On the tick cycle, pb_i is sampled as S. State, counter and flags update at the end of the tick cycle, so they are visible one cycle after pb_rd_o.
  - The conditioner holds pb_i high while the button stays pressed, so S=1 means "pressed at any time since the last poll".
- Counter: CNT_W = $clog2(max(HOLD_CNT,DBL_CNT)+1) bits. It never wraps; each state that uses it bounds it.
- FSM, evaluated on ticks only:
  - IDLE: S=1 -> PRESS, cnt=1. S=0 -> stay.
  - PRESS:
    - S=1: cnt+1. If cnt+1==HOLD_CNT: set long flag, held_o=1 -> LONG.
    - S=0 -> WAIT2, cnt=0.
  - WAIT2:
    - S=1: set dbl flag -> PRESS2.
    - S=0: cnt+1. If cnt+1==DBL_CNT: set click flag -> IDLE.
  - PRESS2: S=0 -> IDLE. S=1 -> stay. A second press never produces a long event.
  - LONG: S=0: held_o=0 -> IDLE. S=1 -> stay.
- Event flags:
  - Each bit of evt_o is set by its FSM event.
  - A host read (rd_i) is registered, and evt_o clears on the following cycle.
  - A set takes precedence over a clear on the same cycle, so no event is ever lost.
  - Repeated events while a flag is already set are merged.
- Tick coinciding with rd_i: the two are independent; the FSM-set flags survive.

Optional Feature:
- Macro PB_POLL_DBL_EN.
- Defined: full behaviour as above, including WAIT2 and PRESS2.
- Undefined:
  - WAIT2 and PRESS2 are not built.
  - In PRESS, S=0 sets the click flag immediately -> IDLE.
  - evt_o[1] is tied to 0.
  - DBL_CNT is unused.

Test Plan (POLL_W=4, HOLD_CNT=4, DBL_CNT=3, macro defined unless noted):
- Single click: pb_i high at poll 1, low after -> WAIT2 at poll 2, evt_o=3'b001 one cycle after poll 5. pb_rd_o is a 1-cycle pulse every 16 clocks.
- Double-click: pb_i high at poll 1, low at poll 2, high at poll 3 -> evt_o=3'b010 after poll 3; click never set; IDLE after next low poll.
- Long hold: pb_i high polls 1-4 -> evt_o=3'b100 and held_o=1 after poll 4; pb_i low at poll 6 -> held_o=0, state IDLE.
- Host read collision: rd_i pulsed so its registered clear lands on the cycle a click is set -> evt_o[0] stays 1; a later rd_i clears it to 0.
- Reset mid-LONG: drop rst_n_i during LONG -> held_o, evt_o and pb_rd_o are 0 immediately; next pb_rd_o comes 16 clocks after release.
- Macro undefined: pb_i high at poll 1, low at poll 2 -> evt_o=3'b001 after poll 2; evt_o[1] is 0 throughout.

Source files
------------

// File: rtl/pb_poll.sv
// pb_poll: polls the pushbutton conditioner's clear-on-read flag and classifies
// presses into sticky click / double-click / long-hold events. Macro PB_POLL_DBL_EN enables double-click.
module pb_poll #(
  parameter int POLL_W   = 16,
  parameter int HOLD_CNT = 50,
  parameter int DBL_CNT  = 15
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       pb_i,
  output logic       pb_rd_o,
  input  logic       rd_i,
  output logic [2:0] evt_o,
  output logic       held_o
);

  localparam int CNT_MAX = (HOLD_CNT > DBL_CNT) ? HOLD_CNT : DBL_CNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CNT);
`ifdef PB_POLL_DBL_EN
  localparam logic [CNT_W-1:0] DBL_LIM = CNT_W'(DBL_CNT);
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS,
    ST_LONG
`ifdef PB_POLL_DBL_EN
    ,
    ST_WAIT2,
    ST_PRESS2
`endif
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [POLL_W-1:0] r_poll;
  logic              r_pb_rd;
  logic              r_rd;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              r_held;
  logic              w_held_nxt;
  logic [2:0]        r_evt;
  logic [2:0]        w_evt_set;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_poll  <= '0;
      r_pb_rd <= 1'b0;
      r_rd    <= 1'b0;
    end else begin
      r_poll  <= r_poll + 1'b1;
      r_pb_rd <= &r_poll;
      r_rd    <= rd_i;
    end
  end

  // FSM only advances at the end of the cycle where pb_rd_o is high
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_held  <= w_held_nxt;
    end
  end

  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_held_nxt  = r_held;
    w_evt_set   = 3'b000;
    if (r_pb_rd) begin
      case (r_state)
        ST_IDLE: begin
          if (pb_i) begin
            w_state_nxt = ST_PRESS;
            w_cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_PRESS: begin
          if (pb_i) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == HOLD_LIM) begin
              w_evt_set[2] = 1'b1;
              w_held_nxt   = 1'b1;
              w_state_nxt  = ST_LONG;
            end
          end else begin
            w_cnt_nxt = '0;
`ifdef PB_POLL_DBL_EN
            w_state_nxt = ST_WAIT2;
`else
            w_evt_set[0] = 1'b1;
            w_state_nxt  = ST_IDLE;
`endif
          end
        end
`ifdef PB_POLL_DBL_EN
        ST_WAIT2: begin
          if (pb_i) begin
            w_evt_set[1] = 1'b1;
            w_state_nxt  = ST_PRESS2;
          end else if (w_cnt_inc == DBL_LIM) begin
            w_evt_set[0] = 1'b1;
            w_cnt_nxt    = '0;
            w_state_nxt  = ST_IDLE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        ST_PRESS2: begin
          if (!pb_i) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end
        end
`endif
        ST_LONG: begin
          if (!pb_i) begin
            w_held_nxt  = 1'b0;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_held_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // set wins over the registered host clear so no event is dropped
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_evt <= 3'b000;
    end else begin
      r_evt <= (r_evt & ~{3{r_rd}}) | w_evt_set;
    end
  end

  assign pb_rd_o = r_pb_rd;
  assign evt_o   = r_evt;
  assign held_o  = r_held;

endmodule

// File: tb/tb_pb_poll.sv
// Testbench for pb_poll: scenario tasks plus randomized polling checked
// against a press-history classifier model.
module tb_pb_poll;
  localparam int POLL_W = 4;
  localparam int HOLD   = 4;
  localparam int DBL    = 3;
  localparam int PER    = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pb = 1'b0;
  logic       rd = 1'b0;
  logic       pb_rd_o;
  logic [2:0] evt_o;
  logic       held_o;

  int checks = 0;
  int failures = 0;

  int         k;
  bit         m_rd;
  bit         m_rdq;
  bit         m_held;
  logic [2:0] m_evt;
  bit         hq[$];

  pb_poll #(.POLL_W(POLL_W), .HOLD_CNT(HOLD), .DBL_CNT(DBL)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .pb_i(pb), .pb_rd_o(pb_rd_o),
    .rd_i(rd), .evt_o(evt_o), .held_o(held_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic model_reset;
    k = 0; m_rd = 0; m_rdq = 0; m_held = 0; m_evt = 3'b000;
    hq.delete();
  endtask

  // classify the press episode from the history of samples since it began
  task automatic model_sample(input bit s, output logic [2:0] setv);
    int n;
    int a;
`ifdef PB_POLL_DBL_EN
    int z;
`endif
    setv = 3'b000;
    if (hq.size() == 0) begin
      if (s) hq.push_back(1'b1);
      return;
    end
    hq.push_back(s);
    n = hq.size();
    a = 0;
    while (a < n && hq[a]) a++;
    if (a >= HOLD) begin
      if (n == HOLD && s) begin setv[2] = 1'b1; m_held = 1'b1; end
      if (!s) begin m_held = 1'b0; hq.delete(); end
    end else if (a < n) begin
`ifdef PB_POLL_DBL_EN
      z = 0;
      while (a + z < n && !hq[a+z]) z++;
      if (z == DBL) begin
        setv[0] = 1'b1; hq.delete();
      end else if (a + z < n) begin
        if (n == a + z + 1) setv[1] = 1'b1;
        if (!s) hq.delete();
      end
`else
      setv[0] = 1'b1; hq.delete();
`endif
    end
  endtask

  task automatic cyc;
    logic [2:0] setv;
    @(posedge clk);
    if (rst_n) begin
      setv = 3'b000;
      if (m_rd) model_sample(pb, setv);
      m_evt = (m_evt & ~{3{m_rdq}}) | setv;
      m_rdq = rd;
      k++;
      m_rd = (k % PER == 0);
    end
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0; pb = 1'b0; rd = 1'b0;
    model_reset();
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic run_poll(input bit s, input int rd_at);
    pb = s;
    for (int j = 0; j < PER; j++) begin
      rd = (j == rd_at);
      cyc();
    end
    rd = 1'b0;
  endtask

  task automatic test_reset;
    int edges;
    rst_n = 1'b1;
    repeat (5) cyc();
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (pb_rd_o !== 1'b0) begin failures++; $display("FAIL reset_pb_rd got=%b exp=0", pb_rd_o); end
    checks++; if (evt_o !== 3'b000) begin failures++; $display("FAIL reset_evt got=%b exp=000", evt_o); end
    checks++; if (held_o !== 1'b0) begin failures++; $display("FAIL reset_held got=%b exp=0", held_o); end
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    for (int j = 0; j < 40; j++) begin
      cyc();
      edges++;
      checks++; if (pb_rd_o !== m_rd) begin failures++; $display("FAIL reset_tick_model got=%b exp=%b", pb_rd_o, m_rd); end
      if (pb_rd_o) break;
    end
    checks++; if (edges != PER) begin failures++; $display("FAIL reset_first_tick got=%0d exp=%0d", edges, PER); end
  endtask

  task automatic test_click;
    int pulses;
    bit pat[6] = '{1, 0, 0, 0, 0, 0};
`ifdef PB_POLL_DBL_EN
    int click_poll = 5;
`else
    int click_poll = 2;
`endif
    do_reset();
    for (int p = 0; p < 5; p++) begin
      run_poll(pat[p], -1);
      checks++; if (evt_o !== m_evt) begin failures++; $display("FAIL click_evt_model poll=%0d got=%b exp=%b", p+1, evt_o, m_evt); end
      if (p + 1 == click_poll - 1) begin
        checks++; if (evt_o !== 3'b000) begin failures++; $display("FAIL click_early got=%b exp=000", evt_o); end
      end
      if (p + 1 == click_poll) begin
        checks++; if (evt_o !== 3'b001) begin failures++; $display("FAIL click_evt got=%b exp=001", evt_o); end
      end
    end
    pb = pat[5];
    pulses = 0;
    for (int j = 0; j < PER; j++) begin
      cyc();
      if (pb_rd_o) pulses++;
      checks++; if (pb_rd_o !== m_rd) begin failures++; $display("FAIL click_pb_rd cyc=%0d got=%b exp=%b", j, pb_rd_o, m_rd); end
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL click_pulse_count got=%0d exp=1", pulses); end
  endtask

  task automatic test_double;
    bit pat[7] = '{1, 0, 1, 0, 0, 0, 0};
    do_reset();
    for (int p = 0; p < 7; p++) begin
      run_poll(pat[p], -1);
      checks++; if (evt_o !== m_evt) begin failures++; $display("FAIL dbl_evt_model poll=%0d got=%b exp=%b", p+1, evt_o, m_evt); end
`ifdef PB_POLL_DBL_EN
      if (p >= 2) begin
        checks++; if (evt_o !== 3'b010) begin failures++; $display("FAIL dbl_evt poll=%0d got=%b exp=010", p+1, evt_o); end
      end
`else
      checks++; if (evt_o[1] !== 1'b0) begin failures++; $display("FAIL dbl_bit_tied poll=%0d got=%b exp=0", p+1, evt_o[1]); end
      if (p >= 1) begin
        checks++; if (evt_o !== 3'b001) begin failures++; $display("FAIL dbl_off_click poll=%0d got=%b exp=001", p+1, evt_o); end
      end
`endif
    end
  endtask

  task automatic test_long;
    bit pat[6] = '{1, 1, 1, 1, 1, 0};
    bit hexp[6] = '{0, 0, 0, 1, 1, 0};
    do_reset();
    for (int p = 0; p < 6; p++) begin
      run_poll(pat[p], -1);
      checks++; if (held_o !== hexp[p]) begin failures++; $display("FAIL long_held poll=%0d got=%b exp=%b", p+1, held_o, hexp[p]); end
      checks++; if (evt_o !== m_evt) begin failures++; $display("FAIL long_evt_model poll=%0d got=%b exp=%b", p+1, evt_o, m_evt); end
    end
    checks++; if (evt_o !== 3'b100) begin failures++; $display("FAIL long_evt got=%b exp=100", evt_o); end
  endtask

  task automatic test_collision;
`ifdef PB_POLL_DBL_EN
    int npre = 4;
`else
    int npre = 1;
`endif
    do_reset();
    for (int p = 0; p < npre; p++) run_poll(p == 0, -1);
    run_poll(1'b0, 14);
    checks++; if (evt_o !== 3'b001) begin failures++; $display("FAIL collide_keep got=%b exp=001", evt_o); end
    run_poll(1'b0, 3);
    checks++; if (evt_o !== 3'b000) begin failures++; $display("FAIL collide_clear got=%b exp=000", evt_o); end
    checks++; if (evt_o !== m_evt) begin failures++; $display("FAIL collide_model got=%b exp=%b", evt_o, m_evt); end
  endtask

  task automatic test_reset_mid_long;
    int edges;
    do_reset();
    for (int p = 0; p < 4; p++) run_poll(1'b1, -1);
    checks++; if (held_o !== 1'b1) begin failures++; $display("FAIL midlong_enter got=%b exp=1", held_o); end
    pb = 1'b1;
    for (int j = 0; j < PER - 1; j++) cyc();
    checks++; if (pb_rd_o !== 1'b1) begin failures++; $display("FAIL midlong_tick got=%b exp=1", pb_rd_o); end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if ({held_o, evt_o, pb_rd_o} !== 5'b0) begin failures++; $display("FAIL midlong_abort got=%b exp=00000", {held_o, evt_o, pb_rd_o}); end
    pb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    for (int j = 0; j < 40; j++) begin
      cyc();
      edges++;
      if (pb_rd_o) break;
    end
    checks++; if (edges != PER) begin failures++; $display("FAIL midlong_first_tick got=%0d exp=%0d", edges, PER); end
    checks++; if ({held_o, evt_o} !== 4'b0) begin failures++; $display("FAIL midlong_after got=%b exp=0000", {held_o, evt_o}); end
  endtask

  task automatic test_random;
    bit s;
    do_reset();
    s = 1'b0;
    for (int p = 0; p < 50; p++) begin
      if ($urandom_range(0, 9) < 3) s = ~s;
      pb = s;
      for (int j = 0; j < PER; j++) begin
        rd = ($urandom_range(0, 11) == 0);
        cyc();
        checks++;
        if (pb_rd_o !== m_rd || evt_o !== m_evt || held_o !== m_held) begin
          failures++;
          $display("FAIL random poll=%0d cyc=%0d got rd=%b evt=%b held=%b exp rd=%b evt=%b held=%b",
                   p, j, pb_rd_o, evt_o, held_o, m_rd, m_evt, m_held);
        end
      end
    end
    rd = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_click();
    test_double();
    test_long();
    test_collision();
    test_reset_mid_long();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
